// File: rtl/data_memory_ctrl.sv
// RV32 data memory for the MEM stage: valid/ready request, programmable wait
// states, B/H/W loads and stores with sign/zero extension and fault reporting.
module data_memory_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WIDTH-1:0]  req_wdata_i,
  output logic              rsp_valid_o,
  output logic [WIDTH-1:0]  rsp_rdata_o,
  output logic              rsp_err_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               err_q;
  logic               accept, commit;

  logic [WIDTH-1:0]   mem_q [DEPTH] = '{default: '0};

  // With zero wait states the commit edge is the acceptance edge, so the
  // request is taken straight from the inputs while idle.
  logic               cur_we;
  logic [2:0]         cur_f3;
  logic [ADDR_W-1:0]  cur_addr;
  logic [WIDTH-1:0]   cur_wdata;
  logic [1:0]         lane;
  logic [IDX_W-1:0]   idx_lo;
  logic               oob, err;
  logic [WIDTH-1:0]   old_w, wd, ld, merged;
  logic [3:0]         be;
  logic [7:0]         byte_v;
  logic [15:0]        half_v;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        accept = 1'b1;
        if (WAIT_STATES > 0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end else begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d = S_RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_we    = (state_q == S_IDLE) ? req_we_i     : we_q;
    cur_f3    = (state_q == S_IDLE) ? req_funct3_i : f3_q;
    cur_addr  = (state_q == S_IDLE) ? req_addr_i   : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata_i  : wdata_q;
    lane      = cur_addr[1:0];
    idx_lo    = cur_addr[IDX_W+1:2];
    oob       = {2'b00, cur_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
    old_w     = mem_q[idx_lo];
    byte_v    = 8'(old_w >> {lane, 3'b000});
    half_v    = 16'(old_w >> {cur_addr[1], 4'b0000});
  end

  always_comb begin
    err = 1'b0;
    be  = 4'b0000;
    wd  = '0;
    ld  = '0;
    case (cur_f3)
      3'b000: begin
        be = 4'b0001 << lane;
        wd = {4{cur_wdata[7:0]}};
        ld = {{24{byte_v[7]}}, byte_v};
      end
      3'b100: begin
        ld  = {24'b0, byte_v};
        err = cur_we;
      end
      3'b001: begin
        be  = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{cur_wdata[15:0]}};
        ld  = {{16{half_v[15]}}, half_v};
        err = cur_addr[0];
      end
      3'b101: begin
        ld  = {16'b0, half_v};
        err = cur_we | cur_addr[0];
      end
      3'b010: begin
        be  = 4'b1111;
        wd  = cur_wdata;
        ld  = old_w;
        err = (lane != 2'b00);
      end
      default: err = 1'b1;
    endcase
    if (oob) err = 1'b1;
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = be[b] ? wd[8*b +: 8] : old_w[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        rdata_q <= (err || cur_we) ? '0 : ld;
        err_q   <= err;
      end
    end
  end

  // The array has no reset; a reset before the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_ni && commit && cur_we && !err) mem_q[idx_lo] <= merged;
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance with no wait states, one with three,
// checked against a byte-addressed reference memory.
module tb_data_memory_ctrl;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  logic        we_s [2];
  logic [2:0]  f3_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic        rdy [2];
  logic        rsp_v [2];
  logic        err_o [2];
  logic [31:0] rd_o [2];

  int checks = 0;
  int errors = 0;
  logic [7:0] mm [2][DEPTH*4];

  always #5 clk = ~clk;

  data_memory_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_ni(rst_n), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
    .req_we_i(we_s[0]), .req_funct3_i(f3_s[0]), .req_addr_i(addr_s[0]),
    .req_wdata_i(wdata_s[0]), .rsp_valid_o(rsp_v[0]), .rsp_rdata_o(rd_o[0]),
    .rsp_err_o(err_o[0]));

  data_memory_ctrl #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_ni(rst_n), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
    .req_we_i(we_s[1]), .req_funct3_i(f3_s[1]), .req_addr_i(addr_s[1]),
    .req_wdata_i(wdata_s[1]), .rsp_valid_o(rsp_v[1]), .rsp_rdata_o(rd_o[1]),
    .rsp_err_o(err_o[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte array, access size from funct3, alignment by modulo.
  task automatic model(input int s, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output logic [31:0] rd);
    int sz;
    bit sgn;
    logic [31:0] v;
    sz = 0; sgn = 0; e = 1'b0; rd = '0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: sz = 0;
    endcase
    if (sz == 0 || (a % sz) != 0 || (a / 4) >= DEPTH || (we && f3[2])) e = 1'b1;
    else if (we) begin
      for (int i = 0; i < sz; i++) mm[s][a+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[s][a+i];
      if (sgn && sz < 4 && v[8*sz-1])
        for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endtask

  task automatic xact(input int s, input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e);
    logic me;
    logic [31:0] mr;
    int lat;
    chk("ready_idle", 32'(rdy[s]), 32'd1);
    vld[s] = 1'b1; we_s[s] = we; f3_s[s] = f3; addr_s[s] = a; wdata_s[s] = wd;
    @(posedge clk); #1;
    vld[s] = 1'b0; we_s[s] = 1'($urandom); f3_s[s] = 3'($urandom);
    addr_s[s] = $urandom; wdata_s[s] = $urandom;
    lat = 0;
    while (!rsp_v[s] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), (s == 0) ? 32'd0 : 32'd3);
    chk("ready_busy", 32'(rdy[s]), 32'd0);
    model(s, we, f3, a, wd, me, mr);
    rd = rd_o[s]; e = err_o[s];
    chk("rsp_err", 32'(e), 32'(me));
    chk("rsp_rdata", rd, mr);
    @(posedge clk); #1;
    chk("rsp_pulse", 32'(rsp_v[s]), 32'd0);
    chk("ready_back", 32'(rdy[s]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, d, mr;
    logic e, me;
    int n;
    for (int s = 0; s < 2; s++) begin
      vld[s] = 0; we_s[s] = 0; f3_s[s] = 0; addr_s[s] = 0; wdata_s[s] = 0;
      for (int i = 0; i < DEPTH*4; i++) mm[s][i] = 8'h00;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(rdy[s]), 32'd1);
      chk("rst_rspv", 32'(rsp_v[s]), 32'd0);
      chk("rst_rdata", rd_o[s], 32'd0);
      chk("rst_err", 32'(err_o[s]), 32'd0);
    end
    #11 rst_n = 1'b1;

    // Directed, zero wait states
    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, e);
    xact(0, 0, 3'b010, 32'h10, 32'h0, rd, e);      chk("lw10", rd, 32'hDEADBEEF);
    xact(0, 0, 3'b000, 32'h13, 32'h0, rd, e);      chk("lb13", rd, 32'hFFFFFFDE);
    xact(0, 0, 3'b100, 32'h13, 32'h0, rd, e);      chk("lbu13", rd, 32'h000000DE);
    xact(0, 0, 3'b001, 32'h10, 32'h0, rd, e);      chk("lh10", rd, 32'hFFFFBEEF);
    xact(0, 0, 3'b101, 32'h12, 32'h0, rd, e);      chk("lhu12", rd, 32'h0000DEAD);
    xact(0, 1, 3'b000, 32'h11, 32'h55, rd, e);
    xact(0, 0, 3'b010, 32'h10, 32'h0, rd, e);      chk("lw_sb", rd, 32'hDEAD55EF);
    xact(0, 0, 3'b010, 32'h12, 32'h0, rd, e);      chk("lw_mis_err", 32'(e), 32'd1);
    xact(0, 1, 3'b001, 32'h11, 32'h1234, rd, e);   chk("sh_mis_err", 32'(e), 32'd1);
    xact(0, 0, 3'b010, 32'h10, 32'h0, rd, e);      chk("sh_nowrite", rd, 32'hDEAD55EF);
    xact(0, 0, 3'b010, DEPTH*4, 32'h0, rd, e);     chk("oob_err", 32'(e), 32'd1);
    xact(0, 0, 3'b011, 32'h10, 32'h0, rd, e);      chk("f3_011_err", 32'(e), 32'd1);
    xact(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, rd, e); chk("sbu_err", 32'(e), 32'd1);
    xact(0, 0, 3'b010, 32'h10, 32'h0, rd, e);      chk("sbu_nowrite", rd, 32'hDEAD55EF);

    // Three wait states: SW then LW with valid held high, fields jittered while busy
    d = $urandom;
    vld[1] = 1; we_s[1] = 1; f3_s[1] = 3'b010; addr_s[1] = 32'h40; wdata_s[1] = d;
    for (int ev = 0; ev < 12; ev++) begin
      @(posedge clk); #1;
      chk("b2b_rspv", 32'(rsp_v[1]), (ev == 3 || ev == 8) ? 32'd1 : 32'd0);
      chk("b2b_ready", 32'(rdy[1]), (ev == 4 || ev >= 9) ? 32'd1 : 32'd0);
      if (ev == 3 || ev == 8) begin
        model(1, (ev == 3), 3'b010, 32'h40, d, me, mr);
        chk("b2b_rdata", rd_o[1], mr);
        chk("b2b_err", 32'(err_o[1]), 32'(me));
      end
      if (ev == 0) we_s[1] = 0;
      if (ev == 1 || ev == 2) wdata_s[1] = $urandom;
      if (ev == 5) vld[1] = 0;
    end
    chk("b2b_lw_value", rd_o[1], d);

    // Reset during WAIT of a store: no write
    vld[1] = 1; we_s[1] = 1; f3_s[1] = 3'b010; addr_s[1] = 32'h20; wdata_s[1] = 32'hA5A5_5A5A;
    @(posedge clk); #1; vld[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rstw_rspv", 32'(rsp_v[1]), 32'd0);
    chk("rstw_ready", 32'(rdy[1]), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    xact(1, 0, 3'b010, 32'h20, 32'h0, rd, e);      chk("rstw_nowrite", rd, 32'h0);

    // Reset during RESP of a store: write already committed
    d = $urandom;
    vld[1] = 1; we_s[1] = 1; f3_s[1] = 3'b010; addr_s[1] = 32'h24; wdata_s[1] = d;
    @(posedge clk); #1; vld[1] = 0;
    n = 0;
    while (!rsp_v[1] && n < 40) begin @(posedge clk); #1; n++; end
    chk("rstr_lat", 32'(n), 32'd3);
    model(1, 1, 3'b010, 32'h24, d, me, mr);
    rst_n = 1'b0; #1;
    chk("rstr_rspv", 32'(rsp_v[1]), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; #1;
    chk("rstr_ready", 32'(rdy[1]), 32'd1);
    xact(1, 0, 3'b010, 32'h24, 32'h0, rd, e);      chk("rstr_kept", rd, d);

    // Randomized mix on both instances, including illegal and out-of-range
    for (int i = 0; i < 80; i++) begin
      int s;
      logic [2:0] f3;
      logic [31:0] a;
      s = i % 2;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
      a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH*4 + $urandom_range(0, 15))
                                      : 32'($urandom_range(0, 63));
      xact(s, 1'($urandom), f3, a, $urandom, rd, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
